// File: rtl/tictactoe_pkg.sv
// Shared types for the tic-tac-toe board controller: cell codes, result codes,
// controller states and the auto-move cell picker.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    typedef enum logic [1:0] {
        PLAY,
        CHECK,
        DONE
    } state_t;

    // Index 0 is pos1 (top-left), row-major.
    typedef cell_t board_t [9];

    // Returns the 1-based position of the lowest-index empty cell.
    function automatic logic [3:0] lowest_free(input board_t b);
        logic [3:0] r;
        r = 4'd1;
        for (int i = 8; i >= 0; i--) begin
            if (b[i] == EMPTY) r = 4'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ttt_board_ctrl_if.sv
// Move request / board status bundle between the player side, the board
// controller and the winner checker.
interface ttt_board_ctrl_if;
    logic       move_valid;
    logic [3:0] move_pos;
    logic [1:0] winner;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] playerID;
    logic       move_ack;
    logic       move_err;
    logic       timeout;
    logic       game_over;
    logic [1:0] result;

    modport master (
        output move_valid, move_pos,
        input  winner, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  playerID, move_ack, move_err, timeout, game_over, result
    );

    modport slave (
        input  move_valid, move_pos, winner,
        output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output playerID, move_ack, move_err, timeout, game_over, result
    );
endinterface

// File: rtl/ttt_turn_timer.sv
// Per-turn clock counter; expired flags the last allowed clock of a turn.
module ttt_turn_timer #(
    parameter int TURN_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(TURN_CYCLES);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == TW'(TURN_CYCLES - 1));
endmodule

// File: rtl/winner_tie.sv
// Downstream checker: registers the player code owning a complete line, 00 if none.
module winner_tie (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    output logic [1:0] winner
);
    logic [1:0] winner_d;

    function automatic logic [1:0] line(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] c);
        return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
    endfunction

    // Legal play never completes lines for both players, so OR-ing is safe.
    always_comb begin
        winner_d = line(pos1, pos2, pos3) | line(pos4, pos5, pos6) | line(pos7, pos8, pos9)
                 | line(pos1, pos4, pos7) | line(pos2, pos5, pos8) | line(pos3, pos6, pos9)
                 | line(pos1, pos5, pos9) | line(pos3, pos5, pos7);
    end

    always_ff @(posedge clock) begin
        if (reset) winner <= 2'b00;
        else       winner <= winner_d;
    end
endmodule

// File: rtl/ttt_board_ctrl.sv
// Board controller: holds the board and active player, accepts or rejects moves,
// auto-moves on turn expiry, and settles win/tie/next-turn from the winner checker.
module ttt_board_ctrl
    import tictactoe_pkg::*;
#(
    parameter int TURN_CYCLES = 50_000_000,
    parameter int CHECK_WAIT  = 2
) (
    input logic             clock,
    input logic             reset,
    ttt_board_ctrl_if.slave bus
);
    localparam int WW = $clog2(CHECK_WAIT + 1);

    state_t        state_q, state_d;
    board_t        board_q, board_d;
    cell_t         player_q, player_d;
    logic [1:0]    result_q, result_d;
    logic [3:0]    count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          ack_q, ack_d, err_q, err_d, to_q, to_d, over_q, over_d;

    logic       expired, timer_clear, timer_en;
    logic       pos_ok, accept;
    logic [3:0] sel, free_sel;

    ttt_turn_timer #(.TURN_CYCLES(TURN_CYCLES)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    assign sel      = bus.move_pos - 4'd1;
    assign free_sel = lowest_free(board_q) - 4'd1;
    assign pos_ok   = (bus.move_pos >= 4'd1) && (bus.move_pos <= 4'd9);

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        player_d    = player_q;
        result_d    = result_q;
        count_d     = count_q;
        wait_d      = wait_q;
        over_d      = over_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        to_d        = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        accept      = 1'b0;

        case (state_q)
            PLAY: begin
                timer_en = 1'b1;
                accept   = bus.move_valid && pos_ok && (board_q[sel] == EMPTY);
                if (bus.move_valid && !accept) err_d = 1'b1;
                // An accepted move pre-empts expiry; a rejected one does not.
                if (accept || expired) begin
                    if (accept) begin
                        board_d[sel] = player_q;
                        ack_d        = 1'b1;
                    end else begin
                        board_d[free_sel] = player_q;
                        to_d              = 1'b1;
                    end
                    count_d     = count_q + 4'd1;
                    timer_clear = 1'b1;
                    wait_d      = '0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (wait_q == WW'(CHECK_WAIT - 1)) begin
                    if (bus.winner == 2'(player_q)) begin
                        result_d = 2'(player_q);
                        over_d   = 1'b1;
                        state_d  = DONE;
                    end else if (count_q == 4'd9) begin
                        result_d = RES_TIE;
                        over_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        player_d = (player_q == P1) ? P2 : P1;
                        state_d  = PLAY;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE:    ;
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= PLAY;
            board_q  <= '{default: EMPTY};
            player_q <= P1;
            result_q <= RES_NONE;
            count_q  <= 4'd0;
            wait_q   <= '0;
            over_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            player_q <= player_d;
            result_q <= result_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            over_q   <= over_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign bus.pos1      = board_q[0];
    assign bus.pos2      = board_q[1];
    assign bus.pos3      = board_q[2];
    assign bus.pos4      = board_q[3];
    assign bus.pos5      = board_q[4];
    assign bus.pos6      = board_q[5];
    assign bus.pos7      = board_q[6];
    assign bus.pos8      = board_q[7];
    assign bus.pos9      = board_q[8];
    assign bus.playerID  = player_q;
    assign bus.result    = result_q;
    assign bus.game_over = over_q;
    assign bus.move_ack  = ack_q;
    assign bus.move_err  = err_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Scoreboard bench for ttt_board_ctrl with the winner_tie checker in the loop.
module tb_ttt_board_ctrl;
    localparam int EV_ACK  = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_TO   = 2;
    localparam int EV_NONE = 3;

    typedef struct {
        string tag;
        int    kind;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    ttt_board_ctrl_if bus ();

    ttt_board_ctrl #(.TURN_CYCLES(8), .CHECK_WAIT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    winner_tie u_chk (
        .clock  (clock),
        .reset  (reset),
        .pos1   (bus.pos1), .pos2 (bus.pos2), .pos3 (bus.pos3),
        .pos4   (bus.pos4), .pos5 (bus.pos5), .pos6 (bus.pos6),
        .pos7   (bus.pos7), .pos8 (bus.pos8), .pos9 (bus.pos9),
        .winner (bus.winner)
    );

    always #5 clock = ~clock;

    logic [17:0] board_v;
    assign board_v = {bus.pos1, bus.pos2, bus.pos3, bus.pos4, bus.pos5,
                      bus.pos6, bus.pos7, bus.pos8, bus.pos9};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input string tag);
        ev_t e;
        e.tag  = tag;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("spurious_event", kind, EV_NONE);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, kind, e.kind);
        end
    endtask

    always @(negedge clock) begin
        if (bus.move_ack) pop_cmp(EV_ACK);
        if (bus.move_err) pop_cmp(EV_ERR);
        if (bus.timeout)  pop_cmp(EV_TO);
    end

    task automatic drive(input logic [3:0] p);
        @(posedge clock);
        #1 bus.move_valid = 1'b1;
        bus.move_pos = p;
        @(posedge clock);
        #1 bus.move_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clock);
        #1 chk("pending_events", exp_q.size(), 0);
    endtask

    task automatic play(input logic [3:0] p, input string tag);
        push(EV_ACK, tag);
        drive(p);
        settle();
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic bad_move(input logic [3:0] p, input string tag);
        push(EV_ERR, tag);
        drive(p);
        settle();
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_board"}, board_v, 18'h0);
        chk({tag, "_player"}, bus.playerID, 2'b01);
        chk({tag, "_result"}, bus.result, 2'b00);
        chk({tag, "_over"}, bus.game_over, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.move_valid = 1'b0;
        bus.move_pos   = 4'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk_reset_state("por");
        chk("por_pulses", {bus.move_ack, bus.move_err, bus.timeout}, 3'b000);

        // Row win for player 1
        play(1, "t1_m1"); play(4, "t1_m2"); play(2, "t1_m3");
        play(5, "t1_m4");
        chk("t1_not_over_yet", bus.game_over, 1'b0);
        play(3, "t1_m5");
        chk("t1_result", bus.result, 2'b01);
        chk("t1_over", bus.game_over, 1'b1);
        chk("t1_row", {bus.pos1, bus.pos2, bus.pos3}, 6'b010101);
        chk("t1_p2_cells", {bus.pos4, bus.pos5}, 4'b1010);
        drive(6);
        settle();
        chk("t1_done_frozen_pos6", bus.pos6, 2'b00);
        chk("t1_done_frozen_result", bus.result, 2'b01);

        // Reset out of DONE
        do_reset();
        chk_reset_state("rst_done");

        // Occupied cell and out-of-range positions
        play(5, "t2_p1_5");
        bad_move(5, "t2_occupied");
        chk("t2_pos5", bus.pos5, 2'b01);
        chk("t2_player", bus.playerID, 2'b10);
        play(1, "t2_p2_1");
        bad_move(0, "t3_pos0");
        bad_move(10, "t3_pos10");
        chk("t3_board", board_v, {2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
        chk("t3_player", bus.playerID, 2'b01);

        // Turn expiry
        do_reset();
        play(1, "t4_m1");
        play(2, "t4_m2");
        push(EV_TO, "t4_timeout");
        repeat (7) @(posedge clock);
        #1 chk("t4_pos3_before_expiry", bus.pos3, 2'b00);
        @(posedge clock);
        #1 chk("t4_pos3_auto", bus.pos3, 2'b01);
        settle();
        repeat (2) @(posedge clock);
        #1 chk("t4_player_after", bus.playerID, 2'b10);
        repeat (6) @(posedge clock);
        play(9, "t4_move_on_clock8");
        chk("t4_pos9", bus.pos9, 2'b10);
        chk("t4_pos4_untouched", bus.pos4, 2'b00);
        repeat (6) @(posedge clock);
        push(EV_ERR, "t4_err_at_expiry");
        push(EV_TO, "t4_to_at_expiry");
        drive(1);
        settle();
        chk("t4_pos4_auto", bus.pos4, 2'b01);
        chk("t4_pos1_kept", bus.pos1, 2'b01);
        repeat (2) @(posedge clock);
        #1 chk("t4_player_final", bus.playerID, 2'b10);

        // Full board, no line
        do_reset();
        play(1, "t5_m1"); play(2, "t5_m2"); play(3, "t5_m3");
        play(5, "t5_m4"); play(4, "t5_m5"); play(6, "t5_m6");
        play(8, "t5_m7"); play(7, "t5_m8");
        chk("t5_result_mid", bus.result, 2'b00);
        chk("t5_over_mid", bus.game_over, 1'b0);
        play(9, "t5_m9");
        chk("t5_result_tie", bus.result, 2'b11);
        chk("t5_over", bus.game_over, 1'b1);

        // Reset during CHECK with move_valid held
        do_reset();
        push(EV_ACK, "t6_m1");
        drive(1);
        bus.move_valid = 1'b1;
        bus.move_pos   = 4'd5;
        do_reset();
        bus.move_valid = 1'b0;
        chk_reset_state("rst_check");
        settle();

        // move_valid held through CHECK is ignored
        push(EV_ACK, "t6_m2");
        drive(1);
        bus.move_valid = 1'b1;
        bus.move_pos   = 4'd5;
        settle();
        @(posedge clock);
        @(posedge clock);
        #1 bus.move_valid = 1'b0;
        settle();
        chk("t6_pos5_ignored", bus.pos5, 2'b00);
        chk("t6_player", bus.playerID, 2'b10);
        play(7, "t6_play_after");
        chk("t6_pos7", bus.pos7, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
